// File: rtl/router_pkg.sv
// Shared definitions for the router output-side arbiters.
// Optional feature macro: ROUTER_ARBITER_SRC_TAG_EN (adds a source-index tag to every queue entry).
package router_pkg;

  // Width of a source index for n requesters; a single requester still needs one bit.
  function automatic int tag_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The output queue is fixed at two entries.
  localparam int QDEPTH = 2;

  // Layout of a queue entry for the standard 8-input, 5-bit-payload arbiter.
  localparam int DEF_NBITS   = 5;
  localparam int DEF_NINPUTS = 8;
`ifdef ROUTER_ARBITER_SRC_TAG_EN
  localparam int DEF_TAG     = $clog2(DEF_NINPUTS);
`endif

  typedef struct packed {
`ifdef ROUTER_ARBITER_SRC_TAG_EN
    logic [DEF_TAG-1:0]   tag;
`endif
    logic [DEF_NBITS-1:0] payload;
  } arb_entry_t;

endpackage

// File: rtl/router_output_arbiter_if.sv
// Request/send bundle between the per-input routers, the arbiter and the output link.
// Optional feature macro: ROUTER_ARBITER_SRC_TAG_EN (widens send_msg by the source tag).
interface router_output_arbiter_if #(
  parameter int p_nbits   = 5,
  parameter int p_ninputs = 8
);
  import router_pkg::*;

  localparam int c_tag = tag_width(p_ninputs);
`ifdef ROUTER_ARBITER_SRC_TAG_EN
  localparam int c_send_w = p_nbits + c_tag;
`else
  localparam int c_send_w = p_nbits;
`endif

  logic [p_ninputs-1:0]         recv_val;
  logic [p_ninputs-1:0]         recv_rdy;
  logic [p_nbits*p_ninputs-1:0] recv_msg;
  logic                         send_val;
  logic                         send_rdy;
  logic [c_send_w-1:0]          send_msg;

  // Environment side: routers drive requests, the link drives send_rdy.
  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg
  );

  // Arbiter side.
  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg
  );

endinterface

// File: rtl/rr_grant_logic.sv
// Combinational round-robin grant: first requester found walking up from ptr, with wrap.
module rr_grant_logic
  import router_pkg::*;
#(
  parameter int p_ninputs = 8,
  localparam int c_tag    = tag_width(p_ninputs)
) (
  input  logic [p_ninputs-1:0] req,
  input  logic [c_tag-1:0]     ptr,
  output logic [p_ninputs-1:0] grant,
  output logic [c_tag-1:0]     grant_idx
);

  int   idx;
  logic found;

  // Walk ptr, ptr+1, ..., wrapping to 0, and grant the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < p_ninputs; off++) begin
      idx = int'(ptr) + off;
      if (idx >= p_ninputs) begin
        idx = idx - p_ninputs;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = c_tag'(idx);
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Output-port merge stage: round-robin picks one router lane per cycle and
// enqueues its payload into a 2-entry queue that feeds the output link.
// Optional feature macro: ROUTER_ARBITER_SRC_TAG_EN (store and emit the source index).
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int p_nbits   = 5,
  parameter int p_ninputs = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  router_output_arbiter_if.slave io
);

  localparam int c_tag  = tag_width(p_ninputs);
  localparam int c_qptr = $clog2(QDEPTH);

  typedef struct packed {
`ifdef ROUTER_ARBITER_SRC_TAG_EN
    logic [c_tag-1:0]   tag;
`endif
    logic [p_nbits-1:0] payload;
  } entry_t;

  logic [c_tag-1:0]     ptr_q, ptr_d;
  logic [1:0]           count_q, count_d;
  logic [c_qptr-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_qptr-1:0]    rd_ptr_q, rd_ptr_d;
  entry_t               entries_q [QDEPTH];
  entry_t               entries_d [QDEPTH];

  logic [p_ninputs-1:0] grant;
  logic [c_tag-1:0]     grant_idx;
  logic                 full;
  logic                 enq;
  logic                 deq;
  entry_t               new_entry;

  rr_grant_logic #(
    .p_ninputs (p_ninputs)
  ) u_grant (
    .req       (io.recv_val),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Accept side sees only registered count, so send_rdy never reaches recv_rdy.
  assign full        = (count_q == 2'(QDEPTH));
  assign io.recv_rdy = grant & {p_ninputs{~full}};
  assign enq         = |(io.recv_val & io.recv_rdy);

  // Queue head is presented directly from storage.
  assign io.send_val = (count_q != 2'd0);
  assign io.send_msg = entries_q[rd_ptr_q];
  assign deq         = io.send_val & io.send_rdy;

  // Build the entry for the granted lane; payload is passed through untouched.
  always_comb begin
    new_entry         = '0;
    new_entry.payload = io.recv_msg[grant_idx*p_nbits +: p_nbits];
`ifdef ROUTER_ARBITER_SRC_TAG_EN
    new_entry.tag     = grant_idx;
`endif
  end

  // Next-state for pointer, queue storage and occupancy.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    entries_d = entries_q;

    if (enq) begin
      entries_d[wr_ptr_q] = new_entry;
      wr_ptr_d            = wr_ptr_q + 1'b1;
      ptr_d               = (grant_idx == c_tag'(p_ninputs - 1)) ? '0 : grant_idx + 1'b1;
    end

    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // All state; reset clears storage so send_msg reads zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      entries_q <= entries_d;
    end
  end

endmodule
